// File: rtl/memoria_bloco.sv
// Word-addressed single-port data memory for the MEM stage: synchronous write,
// one-cycle registered read, write-first on same-edge collision, range trapping.
module memoria_bloco #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] memEndereco,
    input  logic [DATA_WIDTH-1:0] memValor,
    input  logic                  escreverMemoria,
    input  logic                  lerMemoria,
    output logic [DATA_WIDTH-1:0] saida,
    output logic                  saidaValida,
    output logic                  erroEndereco
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  noIntervalo;
    logic [IDX_W-1:0]      indice;
    logic                  escrita;
    logic                  leitura;

    // Full-width compare: high address bits must never alias onto a valid word.
    always_comb begin
        noIntervalo = ({1'b0, memEndereco} < DEPTH_EXT);
        indice      = memEndereco[IDX_W-1:0];
        escrita     = escreverMemoria && noIntervalo;
        leitura     = lerMemoria && noIntervalo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (escrita) begin
            mem[indice] <= memValor;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saida        <= '0;
            saidaValida  <= 1'b0;
            erroEndereco <= 1'b0;
        end else begin
            saidaValida  <= lerMemoria;
            erroEndereco <= (escreverMemoria || lerMemoria) && !noIntervalo;
            if (lerMemoria) begin
                if (!leitura) begin
                    saida <= '0;
                end else if (escrita) begin
                    saida <= memValor;
                end else begin
                    saida <= mem[indice];
                end
            end
        end
    end

endmodule

// File: tb/tb_memoria_bloco.sv
// Directed table-driven bench for memoria_bloco with hand-computed expectations.
module tb_memoria_bloco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] memEndereco;
    logic [31:0] memValor;
    logic        escreverMemoria;
    logic        lerMemoria;
    logic [31:0] saida;
    logic        saidaValida;
    logic        erroEndereco;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memoria_bloco #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH(256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memEndereco    (memEndereco),
        .memValor       (memValor),
        .escreverMemoria(escreverMemoria),
        .lerMemoria     (lerMemoria),
        .saida          (saida),
        .saidaValida    (saidaValida),
        .erroEndereco   (erroEndereco)
    );

    typedef struct {
        logic        rstN;
        logic        esc;
        logic        ler;
        logic [31:0] addr;
        logic [31:0] valor;
        logic [31:0] expSaida;
        logic        expValida;
        logic        expErro;
    } vetor_t;

    localparam int NV = 28;
    vetor_t tbl [NV];

    function automatic vetor_t mk(logic rstN, logic esc, logic ler, logic [31:0] addr,
                                  logic [31:0] valor, logic [31:0] es, logic ev, logic ee);
        vetor_t v;
        v.rstN = rstN; v.esc = esc; v.ler = ler; v.addr = addr; v.valor = valor;
        v.expSaida = es; v.expValida = ev; v.expErro = ee;
        return v;
    endfunction

    task automatic chk(string nome, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nome, act, exp);
        end
    endtask

    task automatic aplica(vetor_t v, string nome);
        @(negedge clk);
        rst_n           = v.rstN;
        escreverMemoria = v.esc;
        lerMemoria      = v.ler;
        memEndereco     = v.addr;
        memValor        = v.valor;
        @(posedge clk);
        #1;
        chk({nome, ".saida"},  saida,               v.expSaida);
        chk({nome, ".valida"}, {31'b0, saidaValida}, {31'b0, v.expValida});
        chk({nome, ".erro"},   {31'b0, erroEndereco}, {31'b0, v.expErro});
    endtask

    initial begin
        rst_n = 1'b1; escreverMemoria = 1'b0; lerMemoria = 1'b0;
        memEndereco = '0; memValor = '0;

        //              rst esc ler addr          valor          saida         v  e
        tbl[0]  = mk(0, 0, 0, 32'd0,         32'd0,         32'd0,         0, 0);
        tbl[1]  = mk(1, 1, 0, 32'd1,         32'd100,       32'd0,         0, 0);
        tbl[2]  = mk(1, 0, 1, 32'd1,         32'd0,         32'd100,       1, 0);
        tbl[3]  = mk(1, 0, 0, 32'd1,         32'd0,         32'd100,       0, 0);
        tbl[4]  = mk(1, 0, 0, 32'd2,         32'd5,         32'd100,       0, 0);
        tbl[5]  = mk(1, 0, 0, 32'd3,         32'd6,         32'd100,       0, 0);
        tbl[6]  = mk(1, 0, 1, 32'd5,         32'd0,         32'd0,         1, 0);
        tbl[7]  = mk(1, 1, 0, 32'd5,         32'hDEADBEEF,  32'd0,         0, 0);
        tbl[8]  = mk(1, 0, 1, 32'd5,         32'd0,         32'hDEADBEEF,  1, 0);
        tbl[9]  = mk(1, 0, 1, 32'd4,         32'd0,         32'd0,         1, 0);
        tbl[10] = mk(1, 0, 1, 32'd6,         32'd0,         32'd0,         1, 0);
        tbl[11] = mk(1, 1, 1, 32'd7,         32'd42,        32'd42,        1, 0);
        tbl[12] = mk(1, 0, 1, 32'd1,         32'd0,         32'd100,       1, 0);
        tbl[13] = mk(1, 0, 1, 32'd7,         32'd0,         32'd42,        1, 0);
        tbl[14] = mk(1, 1, 0, 32'd256,       32'd9,         32'd42,        0, 1);
        tbl[15] = mk(1, 0, 0, 32'd256,       32'd9,         32'd42,        0, 0);
        tbl[16] = mk(1, 0, 1, 32'd256,       32'd0,         32'd0,         1, 1);
        tbl[17] = mk(1, 0, 1, 32'd0,         32'd0,         32'd0,         1, 0);
        tbl[18] = mk(1, 1, 0, 32'h80000001,  32'h0000AAAA,  32'd0,         0, 1);
        tbl[19] = mk(1, 0, 1, 32'd1,         32'd0,         32'd100,       1, 0);
        tbl[20] = mk(1, 0, 0, 32'd300,       32'd1,         32'd100,       0, 0);
        tbl[21] = mk(1, 1, 0, 32'd255,       32'd123,       32'd100,       0, 0);
        tbl[22] = mk(1, 0, 1, 32'd255,       32'd0,         32'd123,       1, 0);
        tbl[23] = mk(1, 1, 0, 32'd3,         32'd77,        32'd123,       0, 0);
        tbl[24] = mk(0, 1, 1, 32'd3,         32'd55,        32'd0,         0, 0);
        tbl[25] = mk(1, 0, 1, 32'd3,         32'd0,         32'd77 ^ 32'd77, 1, 0);
        tbl[26] = mk(1, 0, 1, 32'd255,       32'd0,         32'd0,         1, 0);
        tbl[27] = mk(1, 0, 1, 32'd1,         32'd0,         32'd0,         1, 0);

        for (int i = 0; i < NV; i++) begin
            aplica(tbl[i], $sformatf("v%0d", i));
        end

        // Collision sequence: overwrite an existing word while reading it.
        aplica(mk(1, 1, 0, 32'd10,  32'h00001234, 32'd0,         0, 0), "col.wr");
        aplica(mk(1, 0, 1, 32'd10,  32'd0,        32'h00001234,  1, 0), "col.rd0");
        aplica(mk(1, 1, 1, 32'd10,  32'h00005678, 32'h00005678,  1, 0), "col.rw");
        aplica(mk(1, 0, 0, 32'd10,  32'd0,        32'h00005678,  0, 0), "col.idle");
        aplica(mk(1, 0, 1, 32'd10,  32'd0,        32'h00005678,  1, 0), "col.rd1");
        // Out-of-range with both enables: no write, zero read, error flagged.
        aplica(mk(1, 1, 1, 32'd266, 32'hFFFFFFFF, 32'd0,         1, 1), "oor.rw");
        aplica(mk(1, 0, 1, 32'd10,  32'd0,        32'h00005678,  1, 0), "oor.chk");
        // Reset with only ler held, then clearing of a word written before.
        aplica(mk(0, 0, 1, 32'd10,  32'd0,        32'd0,         0, 0), "rst2");
        aplica(mk(1, 0, 1, 32'd10,  32'd0,        32'd0,         1, 0), "rst2.rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
